// File: rtl/simple_processor.sv
// ============================================================================
// simple_processor : 4-cycle accumulator CPU (fetch/decode/mem/exec) core
// Revision 1.0
// ============================================================================
`default_nettype none

module simple_processor #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_WIDTH  = 4,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int DATAMEM_WIDTH = 8,
  parameter int INSADDR_WIDTH = 8,
  parameter int INS_WIDTH     = OPCODE_WIDTH + DATAMEM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INS_WIDTH-1:0]     instr,
  output logic [INSADDR_WIDTH-1:0] instr_addr,
  output logic                     mem_wr,
  output logic [DATAMEM_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic [DATA_WIDTH-1:0]    mem_data_out
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR   = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_JN    = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI   = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NOT = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHL = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SHR = ALU_OP_WIDTH'(7);

  state_t                   state, state_nxt;
  logic [INSADDR_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0]    acc, acc_nxt;
  logic [INS_WIDTH-1:0]     ir, ir_nxt;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [DATAMEM_WIDTH-1:0] operand;
  logic [ALU_OP_WIDTH-1:0]  alu_sel;
  logic [DATA_WIDTH-1:0]    alu_res;
  logic [DATA_WIDTH-1:0]    ldi_val;

  assign opcode       = ir[INS_WIDTH-1 -: OPCODE_WIDTH];
  assign operand      = ir[DATAMEM_WIDTH-1:0];
  assign ldi_val      = {{(DATA_WIDTH-DATAMEM_WIDTH){operand[DATAMEM_WIDTH-1]}}, operand};
  assign instr_addr   = pc;
  assign mem_addr     = operand;
  assign mem_data_out = acc;
  // Decoded from live state so an async reset drops the strobe immediately.
  assign mem_wr       = (state == S_MEM) && (opcode == OP_STORE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_XOR:  alu_sel = ALU_XOR;
      OP_NOT:  alu_sel = ALU_NOT;
      OP_SHL:  alu_sel = ALU_SHL;
      OP_SHR:  alu_sel = ALU_SHR;
      default: alu_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_res = acc + mem_data_in;
    case (alu_sel)
      ALU_ADD: alu_res = acc + mem_data_in;
      ALU_SUB: alu_res = acc - mem_data_in;
      ALU_AND: alu_res = acc & mem_data_in;
      ALU_OR:  alu_res = acc | mem_data_in;
      ALU_XOR: alu_res = acc ^ mem_data_in;
      ALU_NOT: alu_res = ~acc;
      ALU_SHL: alu_res = {acc[DATA_WIDTH-2:0], 1'b0};
      ALU_SHR: alu_res = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      default: alu_res = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    ir_nxt    = ir;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        ir_nxt    = instr;
        state_nxt = S_MEM;
      end
      S_MEM:    state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + INSADDR_WIDTH'(1);
        case (opcode)
          OP_NOP, OP_STORE: ;
          OP_LOAD: acc_nxt = mem_data_in;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_SHL, OP_SHR: acc_nxt = alu_res;
          OP_JMP: pc_nxt = operand[INSADDR_WIDTH-1:0];
          OP_JZ:  if (acc == '0) pc_nxt = operand[INSADDR_WIDTH-1:0];
          OP_JN:  if (acc[DATA_WIDTH-1]) pc_nxt = operand[INSADDR_WIDTH-1:0];
          OP_LDI: acc_nxt = ldi_val;
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALTED;
          end
          default: ;
        endcase
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_simple_processor.sv
// ============================================================================
// tb_simple_processor : ISA-level reference model bench for simple_processor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_simple_processor;

  logic        clk;
  logic        rst;
  logic [11:0] instr;
  logic [7:0]  instr_addr;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [11:0] rom [256];
  logic [31:0] ram [256];

  logic [31:0] m_ram [256];
  logic [7:0]  m_pc;
  logic [31:0] m_acc;
  bit          m_halt;

  int n_total;
  int n_bad;

  simple_processor dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_addr   (instr_addr),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr       <= rom[instr_addr];
    mem_data_in <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= mem_data_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Executes one instruction of the ISA; reports the store it performs, if any.
  task automatic model_step(output bit wr, output logic [7:0] wa, output logic [31:0] wd);
    int          op;
    logic [7:0]  a;
    logic [7:0]  next_pc;
    op      = int'(rom[m_pc][11:8]);
    a       = rom[m_pc][7:0];
    next_pc = m_pc + 8'd1;
    wr = 1'b0; wa = a; wd = m_acc;
    case (op)
      1:  m_acc = m_ram[a];
      2:  begin wr = 1'b1; m_ram[a] = m_acc; end
      3:  m_acc = m_acc + m_ram[a];
      4:  m_acc = m_acc - m_ram[a];
      5:  m_acc = m_acc & m_ram[a];
      6:  m_acc = m_acc | m_ram[a];
      7:  m_acc = m_acc ^ m_ram[a];
      8:  m_acc = ~m_acc;
      9:  m_acc = m_acc << 1;
      10: m_acc = $signed(m_acc) >>> 1;
      11: next_pc = a;
      12: if (m_acc == 0) next_pc = a;
      13: if ($signed(m_acc) < 0) next_pc = a;
      14: m_acc = 32'($signed(a));
      15: begin m_halt = 1'b1; next_pc = m_pc; end
      default: ;
    endcase
    m_pc = next_pc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(instr_addr), 32'h0);
    check("rst_wr", 32'(mem_wr), 32'h0);
    check("rst_acc", mem_data_out, 32'h0);
    for (int i = 0; i < 256; i++) m_ram[i] = ram[i];
    m_pc = 8'd0; m_acc = 32'd0; m_halt = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    bit          wr;
    logic [7:0]  wa;
    logic [31:0] wd;
    for (int i = 0; i < n; i++) begin
      if (!m_halt) begin
        check("pc", 32'(instr_addr), 32'(m_pc));
        check("acc", mem_data_out, m_acc);
        model_step(wr, wa, wd);
        @(negedge clk);
        check("wr_dec", 32'(mem_wr), 32'h0);
        @(negedge clk);
        check("wr_mem", 32'(mem_wr), 32'(wr));
        if (wr) begin
          check("st_addr", 32'(mem_addr), 32'(wa));
          check("st_data", mem_data_out, wd);
        end
        @(negedge clk);
        check("wr_exe", 32'(mem_wr), 32'h0);
        @(negedge clk);
      end else begin
        for (int c = 0; c < 4; c++) begin
          check("halt_pc", 32'(instr_addr), 32'(m_pc));
          check("halt_acc", mem_data_out, m_acc);
          check("halt_wr", 32'(mem_wr), 32'h0);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_ram();
    for (int i = 0; i < 256; i++) check("ram", ram[i], m_ram[i]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin rom[i] = 12'h000; ram[i] = 32'h0; end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst = 1'b0;
    clear_mem();
    @(negedge clk);

    // NOP stepping from address 0
    do_reset();
    run(3);

    // LDI 5; ADD 10; STORE 11
    clear_mem();
    rom[0] = 12'hE05; rom[1] = 12'h30A; rom[2] = 12'h20B; rom[3] = 12'hF00;
    ram[10] = 32'd7;
    do_reset();
    run(6);
    check("m11", ram[11], 32'd12);
    check_ram();

    // LDI -1; ADD 20 -> 0; JZ 0x30 taken
    clear_mem();
    rom[0] = 12'hEFF; rom[1] = 12'h314; rom[2] = 12'hC30; rom[8'h30] = 12'hF00;
    ram[20] = 32'd1;
    do_reset();
    run(5);
    check("jz_tgt", 32'(instr_addr), 32'h30);

    // Overflow into sign bit, JN taken, arithmetic shift right
    clear_mem();
    rom[0] = 12'h140; rom[1] = 12'h341; rom[2] = 12'hD10;
    rom[8'h10] = 12'hA00; rom[8'h11] = 12'hF00;
    ram[8'h40] = 32'h7FFF_FFFF; ram[8'h41] = 32'd1;
    do_reset();
    run(6);
    check("shr_acc", mem_data_out, 32'hC000_0000);
    check("jn_pc", 32'(instr_addr), 32'h11);

    // HALT at address 3 holds for 50+ cycles
    clear_mem();
    rom[3] = 12'hF00;
    do_reset();
    run(17);
    check("halt_at3", 32'(instr_addr), 32'h3);

    // Reset pulse during STORE's MEM cycle must suppress the write
    clear_mem();
    rom[0] = 12'hE05; rom[1] = 12'h20B; rom[2] = 12'hF00;
    ram[11] = 32'h1234;
    do_reset();
    run(1);
    @(negedge clk);
    @(negedge clk);
    check("mid_wr_pre", 32'(mem_wr), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_wr_rst", 32'(mem_wr), 32'h0);
    check("mid_pc_rst", 32'(instr_addr), 32'h0);
    check("mid_acc_rst", mem_data_out, 32'h0);
    @(negedge clk);
    check("mid_m11", ram[11], 32'h1234);
    do_reset();
    run(4);
    check("restart_m11", ram[11], 32'd5);

    // Random programs against the ISA model
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        rom[i] = {op, 8'($urandom)};
        ram[i] = $urandom;
        if ($urandom_range(0, 7) == 0) ram[i] = 32'h0;
      end
      do_reset();
      run(80);
      check_ram();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
